// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SPI-mode SD command frame engine: FSM state
// encodings, frame constants, request types and the frame byte selector.
package sd_cmd_pkg;

    localparam int          FRAME_BITS = 48;
    localparam logic [1:0]  START_BITS = 2'b01;
    localparam logic        END_BIT    = 1'b1;
    localparam logic [7:0]  IDLE_BYTE  = 8'hFF;

    // FSM state encodings, kept as plain constants for legacy tooling.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRE     = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT_R1 = 3'd3;
    localparam logic [2:0] ST_EXT     = 3'd4;
    localparam logic [2:0] ST_BUSY    = 3'd5;
    localparam logic [2:0] ST_TAIL    = 3'd6;

    typedef enum logic [1:0] {REQ_R1, REQ_R1EXT, REQ_R1B} req_t;

    // Byte idx (0 = first on the wire) of the 48-bit command frame.
    function automatic logic [7:0] frame_byte(input logic [5:0]  cmd,
                                              input logic [31:0] arg,
                                              input logic [6:0]  crc,
                                              input logic [2:0]  idx);
        logic [FRAME_BITS-1:0] f;
        f = {START_BITS, cmd, arg, crc, END_BIT};
        case (idx)
            3'd0:    return f[47:40];
            3'd1:    return f[39:32];
            3'd2:    return f[31:24];
            3'd3:    return f[23:16];
            3'd4:    return f[15:8];
            3'd5:    return f[7:0];
            default: return IDLE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/sd_cmd_frame_if.sv
// Controller-side handshake of the SD command frame engine.
// master = SD controller, slave = sd_cmd_frame.
interface sd_cmd_frame_if;
    logic        start;
    logic        start40;
    logic        readit;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        cs_release;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  r1;
    logic [31:0] r_ext;

    modport master (output start, start40, readit, cmd, arg, crc, cs_release,
                    input  busy, done, timeout, r1, r_ext);
    modport slave  (input  start, start40, readit, cmd, arg, crc, cs_release,
                    output busy, done, timeout, r1, r_ext);
endinterface

// File: rtl/sd_spi_byte.sv
// One SPI mode-0 byte transfer: SCK divider, MSB-first TX/RX shifting and a
// byte_done strobe. A go issued in the byte_done cycle chains the next byte
// without stretching the SCK low phase (the divider starts at 1).
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       byte_done
);
    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_r;
    logic             sck_r;
    logic             mosi_r;
    logic [6:0]       tx_sh_r;
    logic [7:0]       rx_sh_r;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       bit_r;
    logic             done_r;

    // Half-period divider, SCK generation, shifting and completion strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= 1'b0;
            sck_r    <= 1'b0;
            mosi_r   <= 1'b1;
            tx_sh_r  <= 7'h7F;
            rx_sh_r  <= 8'hFF;
            div_r    <= '0;
            bit_r    <= 3'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (go) begin
                active_r <= 1'b1;
                sck_r    <= 1'b0;
                div_r    <= DIV_W'(1);
                bit_r    <= 3'd0;
                mosi_r   <= tx_byte[7];
                tx_sh_r  <= tx_byte[6:0];
            end else if (active_r) begin
                if (div_r == DIV_LAST) begin
                    div_r <= '0;
                    if (!sck_r) begin
                        sck_r   <= 1'b1;
                        rx_sh_r <= {rx_sh_r[6:0], miso};
                    end else begin
                        sck_r <= 1'b0;
                        if (bit_r == 3'd7) begin
                            active_r <= 1'b0;
                            done_r   <= 1'b1;
                            mosi_r   <= 1'b1;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            mosi_r  <= tx_sh_r[6];
                            tx_sh_r <= {tx_sh_r[5:0], 1'b1};
                        end
                    end
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end else begin
                mosi_r <= 1'b1;
            end
        end
    end

    assign sck       = sck_r;
    assign mosi      = mosi_r;
    assign rx_byte   = rx_sh_r;
    assign byte_done = done_r;
endmodule

// File: rtl/sd_cmd_frame.sv
// SPI-mode SD command frame engine: sends the 48-bit command frame, waits for
// R1, then optionally collects the 32-bit R3/R7 extension or polls R1b busy.
// Optional feature macro: SD_CMD_PREAMBLE_EN (8 dummy clocks, cs_n high,
// before every frame).
module sd_cmd_frame
    import sd_cmd_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 16,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    sd_cmd_frame_if.slave bus,
    output logic          sck,
    output logic          mosi,
    output logic          cs_n,
    input  logic          miso
);
    localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
`ifdef SD_CMD_PREAMBLE_EN
    localparam logic [2:0]  FIRST_ST  = ST_PRE;
`else
    localparam logic [2:0]  FIRST_ST  = ST_SEND;
`endif

    logic [2:0]  state_r, state_nx_s, post_st_s;
    logic [2:0]  idx_r, idx_nx_s;
    logic        kick_r;
    logic [15:0] cnt_r;
    req_t        req_r;
    logic        readit_r;
    logic [5:0]  cmd_r;
    logic [31:0] arg_r;
    logic [6:0]  crc_r;
    logic        busy_r, done_r, timeout_r, cs_n_r;
    logic [7:0]  r1_r;
    logic [31:0] rext_r;
    logic        accept_s, go_s, byte_done_s;
    logic [7:0]  tx_s, rx_byte_s;

    // A strobe is taken only in IDLE and never in the done cycle itself.
    assign accept_s  = (state_r == ST_IDLE) && !done_r && (bus.start || bus.start40);
    assign post_st_s = readit_r ? ST_IDLE : ST_TAIL;

    // Next-state and SEND byte index selection.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = FIRST_ST;
                    idx_nx_s   = 3'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (byte_done_s) state_nx_s = ST_SEND;
                else             state_nx_s = ST_PRE;
            end
            ST_SEND: begin
                if (!byte_done_s)          state_nx_s = ST_SEND;
                else if (idx_r == 3'd5)    state_nx_s = ST_WAIT_R1;
                else begin
                    state_nx_s = ST_SEND;
                    idx_nx_s   = idx_r + 3'd1;
                end
            end
            ST_WAIT_R1: begin
                if (!byte_done_s)               state_nx_s = ST_WAIT_R1;
                else if (!rx_byte_s[7]) begin
                    if (req_r == REQ_R1EXT)     state_nx_s = ST_EXT;
                    else if (req_r == REQ_R1B)  state_nx_s = ST_BUSY;
                    else                        state_nx_s = post_st_s;
                end
                else if (cnt_r == RESP_LAST)    state_nx_s = post_st_s;
                else                            state_nx_s = ST_WAIT_R1;
            end
            ST_EXT: begin
                if (byte_done_s && cnt_r == 16'd3) state_nx_s = post_st_s;
                else                               state_nx_s = ST_EXT;
            end
            ST_BUSY: begin
                if (byte_done_s && (rx_byte_s == IDLE_BYTE || cnt_r == BUSY_LAST))
                    state_nx_s = post_st_s;
                else
                    state_nx_s = ST_BUSY;
            end
            ST_TAIL: begin
                if (byte_done_s) state_nx_s = ST_IDLE;
                else             state_nx_s = ST_TAIL;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Every phase keeps clocking bytes back to back until the frame ends.
    always_comb begin
        go_s = 1'b0;
        tx_s = IDLE_BYTE;
        if ((kick_r || byte_done_s) && (state_nx_s != ST_IDLE)) begin
            go_s = 1'b1;
            if (state_nx_s == ST_SEND) tx_s = frame_byte(cmd_r, arg_r, crc_r, idx_nx_s);
            else                       tx_s = IDLE_BYTE;
        end else begin
            go_s = 1'b0;
        end
    end

    // Frame control, chip select and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 3'd0;
            kick_r    <= 1'b0;
            cnt_r     <= 16'd0;
            req_r     <= REQ_R1;
            readit_r  <= 1'b0;
            cmd_r     <= 6'd0;
            arg_r     <= 32'd0;
            crc_r     <= 7'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            cs_n_r    <= 1'b1;
            r1_r      <= 8'hFF;
            rext_r    <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            kick_r  <= accept_s;
            done_r  <= 1'b0;
            if (state_nx_s != state_r) cnt_r <= 16'd0;
            else if (byte_done_s)      cnt_r <= cnt_r + 16'd1;
            if (accept_s) begin
                req_r     <= (bus.start && bus.start40) ? REQ_R1B :
                             (bus.start40 ? REQ_R1EXT : REQ_R1);
                readit_r  <= bus.readit;
                cmd_r     <= bus.cmd;
                arg_r     <= bus.arg;
                crc_r     <= bus.crc;
                busy_r    <= 1'b1;
                r1_r      <= 8'hFF;
                rext_r    <= 32'd0;
                timeout_r <= 1'b0;
`ifdef SD_CMD_PREAMBLE_EN
                cs_n_r    <= 1'b1;
`else
                if (bus.cs_release) cs_n_r <= 1'b1;
`endif
            end else if (state_r == ST_IDLE && bus.cs_release) begin
                cs_n_r <= 1'b1;
            end
            if (go_s && state_nx_s == ST_SEND) cs_n_r <= 1'b0;
            if (state_nx_s == ST_TAIL && state_r != ST_TAIL) cs_n_r <= 1'b1;
            if (state_r != ST_IDLE && state_nx_s == ST_IDLE) begin
                done_r <= 1'b1;
                busy_r <= 1'b0;
            end
            if (byte_done_s) begin
                case (state_r)
                    ST_WAIT_R1: begin
                        if (!rx_byte_s[7])            r1_r      <= rx_byte_s;
                        else if (cnt_r == RESP_LAST)  timeout_r <= 1'b1;
                    end
                    ST_EXT:  rext_r <= {rext_r[23:0], rx_byte_s};
                    ST_BUSY: begin
                        if (rx_byte_s != IDLE_BYTE && cnt_r == BUSY_LAST) timeout_r <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk       (clk),
        .rst       (rst),
        .go        (go_s),
        .tx_byte   (tx_s),
        .miso      (miso),
        .sck       (sck),
        .mosi      (mosi),
        .rx_byte   (rx_byte_s),
        .byte_done (byte_done_s)
    );

    assign cs_n        = cs_n_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.timeout = timeout_r;
    assign bus.r1      = r1_r;
    assign bus.r_ext   = rext_r;
endmodule

// File: doc/sd_cmd_frame.md
# sd_cmd_frame

SPI-mode SD command frame engine, directly downstream of the command/CRC7 preparation stage. It accepts a prepared command, argument and CRC7 together with start strobes. It then shifts the 48-bit command frame out on MOSI, polls MISO for the R1 token, and collects either the 32-bit R3/R7 extension or the R1b busy phase. It reports the response to the SD controller, and its SPI pins go directly to the card.

## Interface
- CLK_DIV, 4, system clocks per SCK half-period (≥2)
- RESP_TIMEOUT, 16, max 0xFF-clocked bytes waiting for R1
- BUSY_TIMEOUT, 65535, max bytes polled during R1b busy
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle strobe: send frame, R1 response
- start40  in  1  one-cycle strobe: send frame, R1 + 32-bit response
- readit  in  1  sampled with start/start40; 1 = keep cs_n low after done
- cmd  in  6  command index
- arg  in  32  argument
- crc  in  7  CRC7 of {2'b01,cmd,arg}
- cs_release  in  1  strobe: raise cs_n when held by readit
- busy  out  1  frame in progress
- done  out  1  one-cycle completion pulse
- timeout  out  1  valid with done; response or busy phase timed out
- r1  out  8  R1 byte
- r_ext  out  32  extension bytes, MSB first
- sck, mosi, cs_n  out  1  SPI to card
- miso  in  1  SPI from card

## Operation
- SPI mode 0: SCK idles low; MOSI changes after the falling edge; MISO is sampled on the rising edge. Bit time is 2·CLK_DIV clk cycles.
- Request types: start → R1; start40 → R1+32; start && start40 in the same cycle → R1b (R1 then busy poll).
- States: IDLE → PRE → SEND → WAIT_R1 → (EXT | BUSY)? → TAIL → IDLE.
- IDLE:
  - On a start/start40 strobe, latch cmd, arg, crc, readit and the request type. Set busy.
  - Strobes arriving while busy=1 are ignored.
- PRE: 8 SCK cycles with cs_n=1 and mosi=1. Present only with the macro enabled (see Configuration).
- SEND: cs_n=0. Shift {2'b01, cmd, arg, crc, 1'b1} (48 bits) MSB first.
- WAIT_R1:
  - Clock byte-wise with mosi=1.
  - The first byte with bit7=0 is R1.
  - After RESP_TIMEOUT bytes with bit7=1, set timeout=1, set r1=8'hFF and go to TAIL.
- EXT: 4 further bytes, MSB first, into r_ext.
- BUSY:
  - Poll bytes until a byte equals 8'hFF.
  - After BUSY_TIMEOUT bytes, set timeout=1.
- TAIL:
  - readit=0: cs_n=1, then 8 SCK cycles with mosi=1, then done.
  - readit=1: done immediately, with cs_n held 0 until cs_release. cs_release in any other state is ignored.
- r1, r_ext and timeout hold their values until the next accepted strobe. They are cleared (r1=FF, r_ext=0, timeout=0) at acceptance.
- EXT and BUSY run only when R1 is received without timeout.

## Timing
- Reset values: sck=0, mosi=1, cs_n=1, busy=0, done=0, timeout=0, r1=8'hFF, r_ext=0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately: cs_n=1, no done pulse.
- busy rises the cycle after the strobe and falls in the same cycle done pulses.
- The first SCK rising edge of SEND occurs CLK_DIV cycles after SEND entry.
- For the minimal case (R1 in the first byte, readit=0, no preamble), done arrives (48+8+8)·2·CLK_DIV + 2 cycles after the strobe, ±1 cycle.
- When done pulses in the same cycle as a new strobe, the strobe is ignored; a new strobe is accepted from the cycle after done.
- cs_release and a new strobe in the same cycle: the release applies, and the strobe starts the new frame normally.

## Configuration
- SD_CMD_PREAMBLE_EN
  - Defined: PRE state compiled in, giving 8 dummy clocks with cs_n high before every frame.
  - Undefined: IDLE goes directly to SEND, and latency shrinks by 16·CLK_DIV cycles.

## Structure
- Package sd_cmd_pkg holds:
  - state enum
  - FRAME_BITS=48
  - START_BITS=2'b01
  - END_BIT=1'b1
  - IDLE_BYTE=8'hFF
  - request-type enum {REQ_R1, REQ_R1EXT, REQ_R1B}
- Sub-module sd_spi_byte performs one byte transfer: SCK divider, TX/RX shift, and a byte_done strobe. The FSM reuses it for every phase; SEND uses six byte transfers.

## Test plan
- CMD0: cmd=0, arg=0, crc=7'h4A, start. MISO returns 8'h01 on the 2nd byte → MOSI carries 40 00 00 00 00 95; r1=8'h01, timeout=0, one done pulse.
- CMD8: start40, arg=32'h1AA, crc=7'h43. MISO returns 01 00 00 01 AA → r1=01, r_ext=32'h000001AA.
- Timeout: MISO stuck at 1 → done after RESP_TIMEOUT R1 bytes; r1=FF, timeout=1, cs_n=1.
- R1b: start and start40 together, cmd=12. R1=00, then three 00 bytes, then FF → done after the FF byte; timeout=0.
- readit=1: cs_n stays 0 after done. cs_release → cs_n=1 the next cycle.
- Reset: rst driven low during SEND bit 20 → cs_n=1, busy=0, no done. A start after release completes normally.
